// File: rtl/bmc_acs_sched_pkg.sv
// Shared Viterbi sequencer definitions: FSM states, default geometry and derived widths.
package bmc_acs_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, SWAP} sched_state_t;

  localparam int NUM_STATES_DEF = 64;
  localparam int NUM_UNITS_DEF  = 8;
  localparam int TB_DEPTH_DEF   = 32;

  // A count of one still needs a 1-bit index so that ports never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GRP_W = idx_width(NUM_STATES_DEF / NUM_UNITS_DEF);
  localparam int TB_AW = idx_width(TB_DEPTH_DEF);

endpackage

// File: rtl/bmc_acs_sched_if.sv
// Symbol handshake plus ACS/BMC/survivor control bundle between the sequencer and the datapath.
interface bmc_acs_sched_if
  import bmc_acs_sched_pkg::*;
#(
  parameter int GRP_W = bmc_acs_sched_pkg::GRP_W,
  parameter int TB_AW = bmc_acs_sched_pkg::TB_AW
);
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       rx_pair_in;
  logic [1:0]       rx_pair;
  logic [GRP_W-1:0] grp_idx;
  logic             acs_en;
  logic             pm_wr_en;
  logic             pm_sel;
  logic             norm_req;
  logic             norm_en;
  logic             sv_wr_en;
  logic [TB_AW-1:0] sv_addr;
  logic             step_done;
  logic             tb_start;

  // master is the sequencer; slave is the symbol source and ACS datapath around it.
  modport master (
    input  clr, in_valid, rx_pair_in, norm_req,
    output in_ready, rx_pair, grp_idx, acs_en, pm_wr_en, pm_sel,
           norm_en, sv_wr_en, sv_addr, step_done, tb_start
  );

  modport slave (
    output clr, in_valid, rx_pair_in, norm_req,
    input  in_ready, rx_pair, grp_idx, acs_en, pm_wr_en, pm_sel,
           norm_en, sv_wr_en, sv_addr, step_done, tb_start
  );
endinterface

// File: rtl/bmc_acs_sched_step_ctr.sv
// vit_step_ctr: modulo-DEPTH survivor symbol address with a pulse on the wrapping step.
module vit_step_ctr
  import bmc_acs_sched_pkg::*;
#(
  parameter int DEPTH = TB_DEPTH_DEF,
  parameter int AW    = idx_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          wrap
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  // DEPTH is a power of two, so the natural binary rollover is the modulo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       addr <= '0;
    else if (clr)  addr <= '0;
    else if (step) addr <= addr + 1'b1;
  end

  assign wrap = step & (addr == LAST);
endmodule

// File: rtl/bmc_acs_sched.sv
// Symbol sequencer for the BMC/ACS bank: walks the state groups, swaps path-metric banks,
// schedules normalization and survivor writes, and flags traceback every TB_DEPTH symbols.
module bmc_acs_sched
  import bmc_acs_sched_pkg::*;
#(
  parameter int NUM_STATES = NUM_STATES_DEF,
  parameter int NUM_UNITS  = NUM_UNITS_DEF,
  parameter int TB_DEPTH   = TB_DEPTH_DEF
) (
  input logic             clk,
  input logic             rst,
  bmc_acs_sched_if.master bus
);
  localparam int NGRP      = NUM_STATES / NUM_UNITS;
  localparam int GRP_BITS  = idx_width(NGRP);
  localparam int ADDR_BITS = idx_width(TB_DEPTH);
  localparam logic [GRP_BITS-1:0] GRP_LAST = GRP_BITS'(NGRP - 1);

  sched_state_t        state, state_nxt;
  logic [1:0]          rx_pair;
  logic [GRP_BITS-1:0] grp_idx;
  logic                pm_sel, norm_en, norm_latch;
  logic                in_ready, run_en, step_done;
  logic [ADDR_BITS-1:0] sv_addr;
  logic                tb_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // clr overrides every transition and also suppresses the done pulse of a dropped symbol.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    run_en    = 1'b0;
    step_done = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN: begin
        run_en = 1'b1;
        if (grp_idx == GRP_LAST) state_nxt = SWAP;
      end
      SWAP: begin
        step_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.clr) begin
      state_nxt = IDLE;
      step_done = 1'b0;
    end
  end

  // Requests gathered during one symbol only take effect on the following symbol.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_pair    <= 2'b00;
      grp_idx    <= '0;
      pm_sel     <= 1'b0;
      norm_en    <= 1'b0;
      norm_latch <= 1'b0;
    end else if (bus.clr) begin
      grp_idx    <= '0;
      pm_sel     <= 1'b0;
      norm_en    <= 1'b0;
      norm_latch <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            rx_pair <= bus.rx_pair_in;
            grp_idx <= '0;
          end
        end
        RUN: begin
          grp_idx    <= (grp_idx == GRP_LAST) ? '0 : grp_idx + 1'b1;
          norm_latch <= norm_latch | bus.norm_req;
        end
        SWAP: begin
          pm_sel     <= ~pm_sel;
          norm_en    <= norm_latch;
          norm_latch <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  vit_step_ctr #(.DEPTH(TB_DEPTH), .AW(ADDR_BITS)) u_step_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.clr),
    .step (step_done),
    .addr (sv_addr),
    .wrap (tb_start)
  );

  assign bus.in_ready  = in_ready;
  assign bus.rx_pair   = rx_pair;
  assign bus.grp_idx   = grp_idx;
  assign bus.acs_en    = run_en;
  assign bus.pm_wr_en  = run_en;
  assign bus.sv_wr_en  = run_en;
  assign bus.pm_sel    = pm_sel;
  assign bus.norm_en   = norm_en;
  assign bus.sv_addr   = sv_addr;
  assign bus.step_done = step_done;
  assign bus.tb_start  = tb_start;
endmodule

// File: tb/tb_bmc_acs_sched.sv
// Directed self-checking bench for bmc_acs_sched: default geometry plus a NGRP=1, TB_DEPTH=2 instance.
module tb_bmc_acs_sched;
  import bmc_acs_sched_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   tb_count;

  bmc_acs_sched_if #(.GRP_W(3), .TB_AW(5)) bus ();
  bmc_acs_sched_if #(.GRP_W(1), .TB_AW(1)) bus2 ();

  bmc_acs_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bmc_acs_sched #(.NUM_STATES(64), .NUM_UNITS(64), .TB_DEPTH(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && bus.tb_start) tb_count++;
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One symbol from IDLE; norm_g raises norm_req on that group, clr_g aborts on that group.
  task automatic applyStimulus(input logic [1:0] pair, input int norm_g, input int clr_g,
                               input logic exp_norm);
    bus.in_valid   = 1'b1;
    bus.rx_pair_in = pair;
    checkOutput("sym_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid   = 1'b0;
    bus.rx_pair_in = ~pair;
    for (int g = 0; g < 8; g++) begin
      checkOutput("sym_grp_idx", bus.grp_idx, g);
      checkOutput("sym_norm_en", bus.norm_en, exp_norm);
      checkOutput("sym_rx_pair", bus.rx_pair, pair);
      bus.norm_req = (g == norm_g);
      if (g == clr_g) begin
        bus.clr = 1'b1;
        tick();
        bus.clr      = 1'b0;
        bus.norm_req = 1'b0;
        checkOutput("clr_in_ready", bus.in_ready, 1);
        checkOutput("clr_acs_en", bus.acs_en, 0);
        checkOutput("clr_grp_idx", bus.grp_idx, 0);
        checkOutput("clr_sv_addr", bus.sv_addr, 0);
        checkOutput("clr_pm_sel", bus.pm_sel, 0);
        checkOutput("clr_norm_en", bus.norm_en, 0);
        checkOutput("clr_step_done", bus.step_done, 0);
        checkOutput("clr_rx_pair", bus.rx_pair, pair);
        tick();
        checkOutput("clr_step_done2", bus.step_done, 0);
        checkOutput("clr_in_ready2", bus.in_ready, 1);
        return;
      end
      tick();
    end
    bus.norm_req = 1'b0;
    checkOutput("sym_step_done", bus.step_done, 1);
    checkOutput("sym_norm_en_swap", bus.norm_en, exp_norm);
    tick();
  endtask

  initial begin
    int tb_base;
    total = 0;
    bad = 0;
    tb_count = 0;
    rst = 1'b1;
    bus.clr = 1'b0;  bus.in_valid = 1'b0;  bus.rx_pair_in = 2'b00;  bus.norm_req = 1'b0;
    bus2.clr = 1'b0; bus2.in_valid = 1'b0; bus2.rx_pair_in = 2'b00; bus2.norm_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_acs_en", bus.acs_en, 0);
    checkOutput("rst_grp_idx", bus.grp_idx, 0);
    checkOutput("rst_pm_sel", bus.pm_sel, 0);
    checkOutput("rst_sv_addr", bus.sv_addr, 0);
    checkOutput("rst_rx_pair", bus.rx_pair, 0);
    checkOutput("rst_step_done", bus.step_done, 0);
    checkOutput("rst_tb_start", bus.tb_start, 0);
    checkOutput("rst_norm_en", bus.norm_en, 0);

    // Single symbol, pair 2'b10
    bus.in_valid   = 1'b1;
    bus.rx_pair_in = 2'b10;
    checkOutput("s1_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid   = 1'b0;
    bus.rx_pair_in = 2'b01;
    for (int c = 1; c <= 8; c++) begin
      checkOutput("s1_acs_en", bus.acs_en, 1);
      checkOutput("s1_pm_wr_en", bus.pm_wr_en, 1);
      checkOutput("s1_sv_wr_en", bus.sv_wr_en, 1);
      checkOutput("s1_in_ready_run", bus.in_ready, 0);
      checkOutput("s1_grp_idx", bus.grp_idx, c - 1);
      checkOutput("s1_rx_pair", bus.rx_pair, 2);
      tick();
    end
    checkOutput("s1_step_done", bus.step_done, 1);
    checkOutput("s1_acs_en_swap", bus.acs_en, 0);
    checkOutput("s1_pm_sel_pre", bus.pm_sel, 0);
    checkOutput("s1_sv_addr_pre", bus.sv_addr, 0);
    checkOutput("s1_tb_start", bus.tb_start, 0);
    tick();
    checkOutput("s1_in_ready_post", bus.in_ready, 1);
    checkOutput("s1_pm_sel_post", bus.pm_sel, 1);
    checkOutput("s1_sv_addr_post", bus.sv_addr, 1);
    checkOutput("s1_step_done_post", bus.step_done, 0);
    checkOutput("s1_rx_hold", bus.rx_pair, 2);

    // clr with in_valid in IDLE: nothing accepted, counters cleared
    bus.in_valid   = 1'b1;
    bus.rx_pair_in = 2'b11;
    bus.clr        = 1'b1;
    tick();
    bus.clr = 1'b0;
    checkOutput("clridle_acs_en", bus.acs_en, 0);
    checkOutput("clridle_in_ready", bus.in_ready, 1);
    checkOutput("clridle_sv_addr", bus.sv_addr, 0);
    checkOutput("clridle_pm_sel", bus.pm_sel, 0);
    checkOutput("clridle_rx_pair", bus.rx_pair, 2);

    // Back-to-back: in_valid held for 40 symbols
    tb_base = tb_count;
    for (int s = 0; s < 40; s++) begin
      checkOutput("b2b_in_ready", bus.in_ready, 1);
      tick();
      repeat (8) tick();
      checkOutput("b2b_step_done", bus.step_done, 1);
      checkOutput("b2b_sv_addr", bus.sv_addr, s % 32);
      checkOutput("b2b_tb_start", bus.tb_start, (s == 31) ? 1 : 0);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    checkOutput("b2b_tb_count", tb_count - tb_base, 1);
    checkOutput("b2b_sv_addr_end", bus.sv_addr, 8);
    checkOutput("b2b_pm_sel_end", bus.pm_sel, 0);

    // Normalization on symbol 3, clr at group 4 of symbol 5, then a clean restart
    applyStimulus(2'b00, -1, -1, 1'b0);
    applyStimulus(2'b01, -1, -1, 1'b0);
    applyStimulus(2'b10, 2, -1, 1'b0);
    applyStimulus(2'b11, -1, -1, 1'b1);
    applyStimulus(2'b01, -1, 4, 1'b0);
    applyStimulus(2'b10, -1, -1, 1'b0);
    checkOutput("restart_sv_addr", bus.sv_addr, 1);
    checkOutput("restart_pm_sel", bus.pm_sel, 1);

    // Asynchronous reset between clock edges in the middle of RUN
    bus.in_valid   = 1'b1;
    bus.rx_pair_in = 2'b11;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    checkOutput("arst_pre_acs_en", bus.acs_en, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_acs_en", bus.acs_en, 0);
    checkOutput("arst_grp_idx", bus.grp_idx, 0);
    checkOutput("arst_rx_pair", bus.rx_pair, 0);
    checkOutput("arst_pm_sel", bus.pm_sel, 0);
    checkOutput("arst_sv_addr", bus.sv_addr, 0);
    checkOutput("arst_in_ready", bus.in_ready, 1);
    #1 rst = 1'b0;
    tick();
    checkOutput("arst_post_in_ready", bus.in_ready, 1);
    checkOutput("arst_post_acs_en", bus.acs_en, 0);

    // NGRP=1, TB_DEPTH=2 instance
    bus2.in_valid = 1'b1;
    for (int s = 0; s < 6; s++) begin
      checkOutput("sw_in_ready", bus2.in_ready, 1);
      tick();
      checkOutput("sw_acs_en", bus2.acs_en, 1);
      checkOutput("sw_grp_idx", bus2.grp_idx, 0);
      tick();
      checkOutput("sw_step_done", bus2.step_done, 1);
      checkOutput("sw_acs_en_swap", bus2.acs_en, 0);
      checkOutput("sw_tb_start", bus2.tb_start, s % 2);
      tick();
    end
    bus2.in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
